// File: rtl/if_fetch_unit_pkg.sv
// rtl/if_fetch_unit_pkg.sv - shared fetch-stage types and constants
// Purpose: fetch FSM state encoding, opcode field bounds, PC increment and
//          opcode constants shared with the main controller.
// Ports:   none (package if_pkg).
package if_pkg;

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } fetch_state_e;

  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 21;
  localparam int PC_INC     = 4;

  localparam logic [10:0] OP_LDUR    = 11'b11111000010;
  localparam logic [10:0] OP_STUR    = 11'b11111000000;
  localparam logic [7:0]  OP_CBZ_PFX = 8'b10110100;

endpackage

// File: rtl/if_fetch_unit_if.sv
// rtl/if_fetch_unit_if.sv - instruction memory request/response bundle
// Purpose: groups the fetch-side instruction memory handshake.
// Ports:   imem_req_valid/ready/addr (request), imem_rsp_valid/data (response).
//          master = fetch unit, slave = instruction memory.
interface if_fetch_unit_if #(
  parameter int ADDR_W  = 64,
  parameter int INSTR_W = 32
);

  logic               imem_req_valid;
  logic               imem_req_ready;
  logic [ADDR_W-1:0]  imem_req_addr;
  logic               imem_rsp_valid;
  logic [INSTR_W-1:0] imem_rsp_data;

  modport master (
    output imem_req_valid,
    output imem_req_addr,
    input  imem_req_ready,
    input  imem_rsp_valid,
    input  imem_rsp_data
  );

  modport slave (
    input  imem_req_valid,
    input  imem_req_addr,
    output imem_req_ready,
    output imem_rsp_valid,
    output imem_rsp_data
  );

endinterface

// File: rtl/if_fetch_unit_pc_reg.sv
// rtl/if_fetch_unit_pc_reg.sv - program counter register
// Purpose: holds the fetch PC; redirect loads a word-aligned target, advance
//          loads basePc + 4 (wraps silently modulo 2^ADDR_W).
// Ports:   clk, rst, load/loadPc (redirect), advance/basePc (sequential), pc.
import if_pkg::*;

module if_pc_reg #(
  parameter int                 ADDR_W   = 64,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [ADDR_W-1:0] loadPc,
  input  logic              advance,
  input  logic [ADDR_W-1:0] basePc,
  output logic [ADDR_W-1:0] pc
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= RESET_PC;
    end else if (load) begin
      // Redirect wins over sequential advance; low bits forced to word alignment.
      pc <= {loadPc[ADDR_W-1:2], 2'b00};
    end else if (advance) begin
      pc <= basePc + ADDR_W'(PC_INC);
    end
  end

endmodule

// File: rtl/if_fetch_unit.sv
// rtl/if_fetch_unit.sv - LEGv8 instruction fetch stage
// Purpose: owns the PC, issues one outstanding word read at a time, presents
//          instr/instr_pc/ins_op to decode, and honours branch redirects.
// Ports:   clk, rst (async, active-high); imem (if_fetch_unit_if.master);
//          stall, redirect, redirect_pc in; instr_valid, instr, instr_pc, ins_op out.
//          With IF_PERF_CNT_EN defined: perf_fetched, perf_flushed (saturating).
import if_pkg::*;

module if_fetch_unit #(
  parameter int                ADDR_W   = 64,
  parameter int                INSTR_W  = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst,
  if_fetch_unit_if.master     imem,
  input  logic                stall,
  input  logic                redirect,
  input  logic [ADDR_W-1:0]   redirect_pc,
  output logic                instr_valid,
  output logic [INSTR_W-1:0]  instr,
  output logic [ADDR_W-1:0]   instr_pc,
  output logic [10:0]         ins_op
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]         perf_fetched,
  output logic [31:0]         perf_flushed
`endif
);

  fetch_state_e      state, stateNext;
  logic              drop, dropNext;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] reqPc;
  logic              reqFire;
  logic              rspIn;
  logic              deliver;
  logic              discard;

  // Request valid is held low while reset is asserted even though the state is REQ.
  assign imem.imem_req_valid = (state == REQ) && !rst;
  assign imem.imem_req_addr  = pc;

  assign reqFire = (state == REQ) && imem.imem_req_ready;
  // Responses outside WAIT (e.g. a late pulse after reset) are ignored.
  assign rspIn   = (state == WAIT) && imem.imem_rsp_valid;
  assign deliver = rspIn && !drop && !redirect;
  assign discard = rspIn && (drop || redirect);

  if_pc_reg #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk     (clk),
    .rst     (rst),
    .load    (redirect),
    .loadPc  (redirect_pc),
    .advance (deliver),
    .basePc  (reqPc),
    .pc      (pc)
  );

  always_comb begin
    stateNext = state;
    dropNext  = drop;
    case (state)
      REQ: begin
        if (reqFire) begin
          stateNext = WAIT;
          // A request accepted alongside a redirect fetches the old path.
          dropNext  = redirect;
        end
      end
      WAIT: begin
        if (rspIn) begin
          dropNext  = 1'b0;
          stateNext = (deliver && stall) ? HOLD : REQ;
        end else if (redirect) begin
          dropNext  = 1'b1;
        end
      end
      HOLD: begin
        if (redirect || !stall) stateNext = REQ;
      end
      default: stateNext = REQ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= REQ;
      drop        <= 1'b0;
      reqPc       <= '0;
      instr_valid <= 1'b0;
      instr       <= '0;
      instr_pc    <= '0;
      ins_op      <= '0;
    end else begin
      state <= stateNext;
      drop  <= dropNext;
      if (reqFire) reqPc <= pc;
      if (redirect) begin
        instr_valid <= 1'b0;
      end else if (deliver) begin
        instr_valid <= 1'b1;
        instr       <= imem.imem_rsp_data;
        instr_pc    <= reqPc;
        ins_op      <= imem.imem_rsp_data[OPCODE_MSB:OPCODE_LSB];
      end else if (instr_valid && !stall) begin
        instr_valid <= 1'b0;
      end
    end
  end

`ifdef IF_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetched <= '0;
      perf_flushed <= '0;
    end else begin
      if (deliver && (perf_fetched != '1)) perf_fetched <= perf_fetched + 32'd1;
      if (discard && (perf_flushed != '1)) perf_flushed <= perf_flushed + 32'd1;
    end
  end
`else
  logic unusedDiscard;
  assign unusedDiscard = discard;
`endif

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction fetch stage for the LEGv8 single-issue core.
- Owns the PC and issues word reads to instruction memory over a valid/ready request plus valid response interface.
- Presents the fetched instruction, its PC, and the 11-bit opcode field to the main decoder/controller.
- Consumes the branch-taken redirect that the controller's Branch output produces downstream.

Parameters:
- ADDR_W, 64, PC and memory address width.
- INSTR_W, 32, instruction width.
- RESET_PC, 64'h0, PC value loaded on reset.

Ports:
- clk  in  1  core clock.
- rst  in  1  asynchronous, active-high reset.
- imem_req_valid  out  1  read request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_req_addr  out  ADDR_W  word-aligned fetch address.
- imem_rsp_valid  in  1  read data valid; one pulse per accepted request, any latency ≥1 cycle.
- imem_rsp_data  in  INSTR_W  instruction word.
- stall  in  1  decode cannot accept; hold output.
- redirect  in  1  branch taken (Branch & zero, resolved downstream).
- redirect_pc  in  ADDR_W  branch target.
- instr_valid  out  1  instr/instr_pc/ins_op valid.
- instr  out  INSTR_W  fetched instruction.
- instr_pc  out  ADDR_W  PC of instr.
- ins_op  out  11  instr[31:21], opcode field for the controller.

Behaviour:
- Reset (async, rst=1):
  - pc=RESET_PC, state=REQ.
  - imem_req_valid=0, instr_valid=0, instr=0, instr_pc=0, ins_op=0, drop flag=0.
- States:
  - REQ: imem_req_valid=1, addr=pc. On valid&ready → WAIT, record req_pc=pc.
  - WAIT: await imem_rsp_valid. On response:
    - drop=0: latch instr/instr_pc=req_pc, instr_valid=1, pc=req_pc+4, → HOLD if stall else REQ.
    - drop=1: discard, clear drop, → REQ.
  - HOLD: outputs frozen, imem_req_valid=0. When stall=0 → REQ with instr_valid deasserted the following cycle.
- Output handshake:
  - Instruction is consumed in any cycle where instr_valid=1 and stall=0.
  - instr_valid falls the cycle after consumption unless a new response lands that same cycle.
- Throughput: one outstanding request maximum. Best case is one instruction per 2 cycles with 1-cycle memory.
- Request stability: imem_req_addr must not change while imem_req_valid=1 and ready=0, except on redirect.
- Redirect (highest priority, any state):
  - pc=redirect_pc, instr_valid=0 next cycle.
  - WAIT with response not arriving this cycle: set drop=1, stay WAIT.
  - Response arriving in the same cycle as redirect: discard it, → REQ.
  - REQ: retarget address to redirect_pc. A request accepted in the same cycle as redirect is dropped (drop=1, → WAIT).
  - HOLD: → REQ.
- PC arithmetic: +4 modulo 2^ADDR_W; wrap at all-ones is silent.
- Misalignment: redirect_pc[1:0] is forced to 0.
- ins_op always equals instr[31:21]. Register it with instr; it is not a separate decode.
- Reset mid-transaction: all state cleared. A response arriving after reset with no request issued is ignored (state REQ, not WAIT).

Optional Feature:
- Macro: IF_PERF_CNT_EN
- Defined:
  - Adds outputs perf_fetched[31:0] (instructions delivered with instr_valid rising) and perf_flushed[31:0] (responses discarded via drop or same-cycle redirect).
  - Both reset to 0, saturate at all-ones.
- Undefined: ports and counters absent. Functional behaviour is otherwise identical.

Decomposition:
- Package if_pkg:
  - fetch_state_e enum {REQ, WAIT, HOLD}.
  - OPCODE_MSB=31, OPCODE_LSB=21, PC_INC=4.
  - Opcode constants shared with the controller: OP_LDUR=11'b11111000010, OP_STUR=11'b11111000000, CBZ prefix 8'b10110100.
- Sub-module if_pc_reg: PC register with reset value, increment, redirect mux, and alignment masking.

Test Plan:
- Reset then memory returns 32'hF8400000 at addr 0 with 1-cycle latency, no stall → instr_valid=1, instr_pc=0, ins_op=11'b11111000010. Next request addr=4.
- stall=1 held for 3 cycles after delivery → instr/instr_pc stable, imem_req_valid=0. stall release → request at next PC.
- imem_req_ready=0 for 4 cycles → imem_req_valid=1 and addr=8 held constant. Accepted on cycle 5.
- Redirect to 0x100 while WAIT with 3-cycle memory latency → stale response discarded, instr_valid stays 0. Next request addr=0x100.
- Redirect to 0x200 in the same cycle imem_rsp_valid=1 → response discarded, next addr=0x200. Also redirect_pc=0x203 → addr=0x200.
- rst asserted mid-WAIT, then a late imem_rsp_valid pulse → ignored, first request addr=RESET_PC. With IF_PERF_CNT_EN, counters read 0.
